rom_fetch: RTL and testbench

// Sequential fetch stage directly upstream of the rom block. Holds the program counter and drives the ROM address.

---
 rtl/rom_fetch.sv | 92 +++++++++
 tb/tb_rom_fetch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch.sv
`default_nettype none
// ============================================================================
// Module  : rom_fetch
// Brief   : PC-driven fetch stage that registers ROM words behind valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
module rom_fetch #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int WORDS      = 5,
    parameter int RESET_ADDR = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  error_o
);

    // One extra bit so WORDS == 2**ADDR_WIDTH stays representable.
    localparam logic [ADDR_WIDTH:0]   WORDS_EXT  = (ADDR_WIDTH + 1)'(WORDS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(RESET_ADDR);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_ERROR = 1'b1
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   pc, pc_next;
    logic [DATA_WIDTH-1:0]   instr, instr_next;
    logic [ADDR_WIDTH-1:0]   instr_addr, instr_addr_next;
    logic                    valid, valid_next;
    logic                    fetch;
    logic                    redirect_in_range;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_RUN;
            pc         <= START_ADDR;
            instr      <= '0;
            instr_addr <= '0;
            valid      <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            instr      <= instr_next;
            instr_addr <= instr_addr_next;
            valid      <= valid_next;
        end
    end

    always_comb begin
        state_next        = state;
        pc_next           = pc;
        instr_next        = instr;
        instr_addr_next   = instr_addr;
        valid_next        = valid;
        redirect_in_range = ({1'b0, redirect_addr_i} < WORDS_EXT);
        fetch             = (state == ST_RUN) && en_i && !redirect_i && (!valid || ready_i);

        // Redirect wins over everything and drops any pending word.
        if (redirect_i) begin
            pc_next    = redirect_addr_i;
            valid_next = 1'b0;
            state_next = redirect_in_range ? ST_RUN : ST_ERROR;
        end else if (fetch) begin
            instr_next      = rom_data_i;
            instr_addr_next = pc;
            valid_next      = 1'b1;
            pc_next         = (pc == LAST_ADDR) ? '0 : pc + 1'b1;
        end else if (valid && ready_i) begin
            valid_next = 1'b0;
        end
    end

    assign rom_addr_o   = pc;
    assign instr_o      = instr;
    assign instr_addr_o = instr_addr;
    assign valid_o      = valid;
    assign error_o      = (state == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_rom_fetch
// Brief   : Directed scoreboard bench for rom_fetch against a 5-word ROM model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rom_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic [7:0]  instr_addr;
    logic        valid;
    logic        ready;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] sb_q[$];

    always #5 clk = ~clk;

    assign rom_data = (rom_addr < 8'd5) ? (16'h1000 + {8'h00, rom_addr}) : 16'hDEAD;

    rom_fetch #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(8),
        .WORDS     (5),
        .RESET_ADDR(0)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .en_i           (en),
        .redirect_i     (redirect),
        .redirect_addr_i(redirect_addr),
        .rom_addr_o     (rom_addr),
        .rom_data_i     (rom_data),
        .instr_o        (instr),
        .instr_addr_o   (instr_addr),
        .valid_o        (valid),
        .ready_i        (ready),
        .error_o        (error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] a);
        sb_q.push_back({a, 16'h1000 + {8'h00, a}});
    endtask

    // Bounded wait until the given word is presented on the output.
    task automatic wait_word(input logic [15:0] w);
        bit found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (valid && instr == w) found = 1'b1;
            else step();
        end
        chk($sformatf("wait_word_%h", w), 32'(found), 32'd1);
    endtask

    // Every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_accept", {8'h00, instr_addr, instr}, 32'hFFFFFFFF);
            end else begin
                logic [23:0] e;
                e = sb_q.pop_front();
                chk("accept_word", {8'h00, instr_addr, instr}, {8'h00, e});
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_addr = 8'h00;
        step();
        step();
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_instr_addr", 32'(instr_addr), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);

        // Streaming from reset, stall on 1002
        push_word(8'd0); push_word(8'd1); push_word(8'd2);
        rst_n = 1'b1;
        chk("release_valid", 32'(valid), 32'h0);
        wait_word(16'h1002);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_instr", 32'(instr), 32'h1002);
            chk("stall_valid", 32'(valid), 32'h1);
            chk("stall_rom_addr", 32'(rom_addr), 32'h3);
        end
        ready = 1'b1;
        push_word(8'd3); push_word(8'd4);
        wait_word(16'h1000);
        chk("wrap_instr_addr", 32'(instr_addr), 32'h0);

        // Redirect to 1 while 1000 is stalled; that word is never accepted
        ready = 1'b0;
        step();
        chk("stall2_instr", 32'(instr), 32'h1000);
        redirect = 1'b1; redirect_addr = 8'd1;
        step();
        redirect = 1'b0;
        chk("redir_valid", 32'(valid), 32'h0);
        chk("redir_rom_addr", 32'(rom_addr), 32'h1);
        ready = 1'b1;
        push_word(8'd1); push_word(8'd2);
        wait_word(16'h1003);
        ready = 1'b0;

        // Out-of-range redirect, then recovery
        redirect = 1'b1; redirect_addr = 8'd7;
        step();
        redirect = 1'b0;
        ready = 1'b1;
        chk("err_rom_addr", 32'(rom_addr), 32'h7);
        for (int i = 0; i < 4; i++) begin
            chk("err_level", 32'(error), 32'h1);
            chk("err_valid", 32'(valid), 32'h0);
            step();
        end
        redirect = 1'b1; redirect_addr = 8'd2;
        step();
        redirect = 1'b0;
        chk("recover_error", 32'(error), 32'h0);
        chk("recover_valid", 32'(valid), 32'h0);
        push_word(8'd2); push_word(8'd3); push_word(8'd4);
        wait_word(16'h1004);

        // Fetch disabled for 4 cycles
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("en_off_valid", 32'(valid), 32'h0);
            chk("en_off_rom_addr", 32'(rom_addr), 32'h0);
        end
        en = 1'b1;
        push_word(8'd0); push_word(8'd1);
        step();
        chk("resume_valid", 32'(valid), 32'h1);
        chk("resume_instr", 32'(instr), 32'h1000);
        wait_word(16'h1002);

        // Asynchronous reset in the middle of a stall
        ready = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(valid), 32'h0);
        chk("async_instr", 32'(instr), 32'h0);
        chk("async_instr_addr", 32'(instr_addr), 32'h0);
        chk("async_error", 32'(error), 32'h0);
        chk("async_rom_addr", 32'(rom_addr), 32'h0);
        step();
        rst_n = 1'b1;
        ready = 1'b1;
        push_word(8'd0);
        wait_word(16'h1000);
        step();
        ready = 1'b0;
        step();
        chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
